// File: rtl/cap_touch_pkg.sv
// Shared types and default parameters for the capacitive pad scanner.
package cap_touch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCharge,
        StMeasure,
        StEval
    } scan_state_e;

    localparam int unsigned DefNCh        = 9;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefChargeCyc  = 64;
    localparam int unsigned DefTimeout    = 4095;
    localparam int unsigned DefThresh     = 40;
    localparam int unsigned DefDebN       = 3;
    localparam int unsigned DefGapCyc     = 256;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cap_touch_scanner.sv
// Capacitive pad scanner: charge all pads, time each discharge, compare against a
// calibrated baseline and debounce into stable touch levels and sticky touch events.
module cap_touch_scanner
    import cap_touch_pkg::*;
#(
    parameter int unsigned N_CH       = DefNCh,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned CHARGE_CYC = DefChargeCyc,
    parameter int unsigned TIMEOUT    = DefTimeout,
    parameter int unsigned THRESH     = DefThresh,
    parameter int unsigned DEB_N      = DefDebN,
    parameter int unsigned GAP_CYC    = DefGapCyc,
    localparam int unsigned SelW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CH-1:0]   sensors_in,
    output logic              sensors_out,
    input  logic              calibrate,
    input  logic [N_CH-1:0]   event_clr,
    input  logic [SelW-1:0]   read_sel,
    output logic [CNT_W-1:0]  read_count,
    output logic [N_CH-1:0]   touched,
    output logic [N_CH-1:0]   touch_event,
    output logic              scan_done,
    output logic              calibrated
);

    localparam int unsigned      DebW       = $clog2(DEB_N + 1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GapLast    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] ChargeLast = CNT_W'(CHARGE_CYC - 1);
    localparam logic [DebW-1:0]  DebLast    = DebW'(DEB_N - 1);

    // The shared cycle counter must hold every phase length without wrapping.
    if (CNT_W < 32) begin : g_width_chk
        if (TIMEOUT >= (32'd1 << CNT_W) || GAP_CYC > (32'd1 << CNT_W) ||
            CHARGE_CYC > (32'd1 << CNT_W)) begin : g_bad
            $error("TIMEOUT, GAP_CYC and CHARGE_CYC must fit in CNT_W bits");
        end
    end

    scan_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cyc_q, cyc_d;
    logic [N_CH-1:0]            sens_sync;
    logic [N_CH-1:0]            latched_q, latched_d, fall;
    logic [N_CH-1:0]            touched_q, touched_d, event_q;
    logic                       pend_q, cal_q;
    logic                       meas_exit, cal_eval, norm_eval;
    logic [N_CH-1:0][CNT_W-1:0] counts;

    sync_2ff #(
        .WIDTH(N_CH)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (sensors_in),
        .q    (sens_sync)
    );

    assign fall      = (state_q == StMeasure) ? (~latched_q & ~sens_sync) : '0;
    assign latched_d = latched_q | fall;
    assign meas_exit = (state_q == StMeasure) && ((&latched_d) || (cyc_q == TimeoutVal));
    assign cal_eval  = (state_q == StEval) && pend_q;
    assign norm_eval = (state_q == StEval) && !pend_q && cal_q;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q + CNT_W'(1);
        sensors_out = 1'b0;
        scan_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cyc_q == GapLast) begin
                    state_d = StCharge;
                    cyc_d   = '0;
                end
            end
            StCharge: begin
                sensors_out = 1'b1;
                if (cyc_q == ChargeLast) begin
                    state_d = StMeasure;
                    cyc_d   = '0;
                end
            end
            StMeasure: begin
                if (meas_exit) begin
                    state_d = StEval;
                    cyc_d   = '0;
                end
            end
            StEval: begin
                scan_done = 1'b1;
                state_d   = StIdle;
                cyc_d     = '0;
            end
            default: begin
                state_d = StIdle;
                cyc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    // Pending calibration survives until the next EVAL; a pulse during EVAL arms the following scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            latched_q <= '0;
            pend_q    <= 1'b1;
            cal_q     <= 1'b0;
            touched_q <= '0;
            event_q   <= '0;
        end else begin
            if (state_q == StCharge) begin
                latched_q <= '0;
            end else if (state_q == StMeasure) begin
                latched_q <= latched_d;
            end
            pend_q    <= calibrate | (pend_q & (state_q != StEval));
            cal_q     <= cal_q | cal_eval;
            touched_q <= touched_d;
            event_q   <= (event_q & ~event_clr) | (touched_d & ~touched_q);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] meas_q, count_q, base_q;
        logic [DebW-1:0]  deb_q;
        logic [CNT_W:0]   limit;
        logic             raw, differ, flip;

        assign limit        = {1'b0, base_q} + (CNT_W + 1)'(THRESH);
        assign raw          = {1'b0, count_q} >= limit;
        assign differ       = raw != touched_q[i];
        assign flip         = norm_eval && differ && (deb_q == DebLast);
        assign touched_d[i] = touched_q[i] ^ flip;
        assign counts[i]    = count_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                meas_q  <= '0;
                count_q <= '0;
                base_q  <= '0;
                deb_q   <= '0;
            end else begin
                if (fall[i]) begin
                    meas_q <= cyc_q;
                end
                if (meas_exit) begin
                    count_q <= fall[i] ? cyc_q : (latched_q[i] ? meas_q : TimeoutVal);
                end
                if (cal_eval) begin
                    base_q <= count_q;
                end
                if (norm_eval) begin
                    deb_q <= (differ && deb_q != DebLast) ? deb_q + DebW'(1) : '0;
                end
            end
        end
    end

    assign read_count  = (32'(read_sel) < N_CH) ? counts[read_sel] : '0;
    assign touched     = touched_q;
    assign touch_event = event_q;
    assign calibrated  = cal_q;

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Directed bench for cap_touch_scanner: pad models driven from the charge line, a
// scan-level reference model checked every cycle, plus literal spot checks.
module tb_cap_touch_scanner;

    localparam int N     = 9;
    localparam int CNT_W = 16;
    localparam int CHG   = 64;
    localparam int TMO   = 4095;
    localparam int THR   = 40;
    localparam int DEBN  = 3;
    localparam int GAP   = 256;
    localparam int NEVER = 1000000;
    localparam int LIMIT = 20000;

    logic             clock      = 1'b0;
    logic             reset      = 1'b1;
    logic [N-1:0]     sensors_in = '0;
    logic             sensors_out;
    logic             calibrate  = 1'b0;
    logic [N-1:0]     event_clr  = '0;
    logic [3:0]       read_sel   = '0;
    logic [CNT_W-1:0] read_count;
    logic [N-1:0]     touched;
    logic [N-1:0]     touch_event;
    logic             scan_done;
    logic             calibrated;

    int checks   = 0;
    int failures = 0;

    int k_cfg  [N];
    int k_scan [N];
    int dcnt = 0;

    int           m_cnt  [N];
    int           m_base [N];
    int           m_deb  [N];
    logic [N-1:0] m_touch = '0;
    logic [N-1:0] m_evt   = '0;
    logic         m_cal   = 1'b0;
    logic         m_pend  = 1'b1;
    int           phase   = 0;
    int           hi_n    = 0;
    int           meas_n  = 0;
    int           gap_n   = 0;

    cap_touch_scanner dut (
        .clock      (clock),
        .reset      (reset),
        .sensors_in (sensors_in),
        .sensors_out(sensors_out),
        .calibrate  (calibrate),
        .event_clr  (event_clr),
        .read_sel   (read_sel),
        .read_count (read_count),
        .touched    (touched),
        .touch_event(touch_event),
        .scan_done  (scan_done),
        .calibrated (calibrated)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int k);
        return (k > TMO) ? TMO : k;
    endfunction

    // Pads follow the charge line; each releases so its synchronised value first
    // reads 0 at measure cycle k (two synchroniser flops of latency).
    always @(negedge clock) begin
        if (sensors_out) begin
            dcnt = 0;
            for (int i = 0; i < N; i++) k_scan[i] = k_cfg[i];
            sensors_in = '1;
        end else begin
            for (int i = 0; i < N; i++) sensors_in[i] = (dcnt < k_scan[i] - 2);
            dcnt++;
        end
    end

    always @(negedge clock) begin : model
        logic [N-1:0] nt;
        logic         raw;
        int           mx;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_base[i] = 0;
                m_deb[i]  = 0;
            end
            m_touch = '0;
            m_evt   = '0;
            m_cal   = 1'b0;
            m_pend  = 1'b1;
            phase   = 0;
        end else begin
            if (scan_done) check("scan_done_only_after_measure", phase, 2);
            if (sensors_out) begin
                if (phase != 1) begin
                    if (phase == 3) check("gap_len", gap_n, GAP);
                    phase = 1;
                    hi_n  = 0;
                end
                hi_n++;
            end else if (phase == 1) begin
                check("charge_len", hi_n, CHG);
                phase  = 2;
                meas_n = 1;
            end else if (phase == 2) begin
                if (scan_done) begin
                    mx = 0;
                    for (int i = 0; i < N; i++) if (exp_cnt(k_scan[i]) > mx) mx = exp_cnt(k_scan[i]);
                    check("measure_len", meas_n, mx + 1);
                    phase = 3;
                    gap_n = 0;
                end else begin
                    meas_n++;
                end
            end else if (phase == 3) begin
                gap_n++;
            end

            if (scan_done) for (int i = 0; i < N; i++) m_cnt[i] = exp_cnt(k_scan[i]);

            check("read_count", read_count, (read_sel < N) ? m_cnt[read_sel] : 0);
            check("touched", touched, m_touch);
            check("touch_event", touch_event, m_evt);
            check("calibrated", calibrated, m_cal);

            nt = m_touch;
            if (scan_done) begin
                if (m_pend) begin
                    for (int i = 0; i < N; i++) m_base[i] = m_cnt[i];
                    m_cal = 1'b1;
                end else if (m_cal) begin
                    for (int i = 0; i < N; i++) begin
                        raw = (m_cnt[i] >= m_base[i] + THR);
                        if (raw != m_touch[i]) begin
                            m_deb[i]++;
                            if (m_deb[i] == DEBN) begin
                                nt[i]    = ~nt[i];
                                m_deb[i] = 0;
                            end
                        end else begin
                            m_deb[i] = 0;
                        end
                    end
                end
            end
            m_evt   = (m_evt & ~event_clr) | (nt & ~m_touch);
            m_touch = nt;
            m_pend  = calibrate | (m_pend & !scan_done);
        end
    end

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    // Returns #1 after the edge that enters EVAL.
    task automatic wait_scan();
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!scan_done && n < LIMIT);
        check("scan_seen", scan_done, 1);
    endtask

    task automatic wait_charge();
        int n = 0;
        while (!sensors_out && n < LIMIT) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("charge_seen", sensors_out, 1);
    endtask

    task automatic wait_measure();
        int n = 0;
        wait_charge();
        while (sensors_out && n < LIMIT) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic measure_scan(output int len);
        wait_measure();
        len = 0;
        while (!scan_done && len < LIMIT) begin
            @(posedge clock);
            #1;
            len++;
        end
    endtask

    initial begin
        int len;
        for (int i = 0; i < N; i++) begin
            k_cfg[i]  = 10;
            k_scan[i] = 10;
            m_cnt[i]  = 0;
            m_base[i] = 0;
            m_deb[i]  = 0;
        end
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_sensors_out", sensors_out, 0);
        check("rst_touched", touched, 0);
        check("rst_touch_event", touch_event, 0);
        check("rst_calibrated", calibrated, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_read_count", read_count, 0);
        reset = 1'b1;

        // First scan after reset is a calibration scan: all pads at 10.
        measure_scan(len);
        check("cal_measure_cycles", len, 11);
        settle();
        check("cal_calibrated", calibrated, 1);
        check("cal_touched", touched, 0);
        read_sel = 3;
        #1 check("baseline_count3", read_count, 10);

        for (int s = 0; s < 5; s++) begin
            wait_scan();
            settle();
            check("quiet_touched", touched, 0);
        end

        // Pad 3 pressed: level changes only on the third agreeing scan.
        k_cfg[3] = 60;
        for (int s = 0; s < 3; s++) begin
            wait_scan();
            settle();
            check("press3_touched", touched[3], (s == 2));
        end
        check("press3_event", touch_event, 9'h008);
        check("press3_count", read_count, 60);
        wait_scan();
        settle();
        check("press3_sticky", touch_event[3], 1);
        event_clr = 9'h008;
        settle();
        event_clr = '0;
        check("press3_event_cleared", touch_event[3], 0);
        check("press3_still_touched", touched[3], 1);

        // Pad 5 glitches for two scans only.
        k_cfg[5] = 60;
        for (int s = 0; s < 5; s++) begin
            if (s == 2) k_cfg[5] = 10;
            wait_scan();
            settle();
            check("glitch5_touched", touched[5], 0);
        end

        // Pad 3 released.
        k_cfg[3] = 10;
        for (int s = 0; s < 3; s++) begin
            wait_scan();
            settle();
            check("release3_touched", touched[3], (s != 2));
        end

        // Pad 3 pressed again with a clear landing on the same edge as the rise.
        k_cfg[3] = 60;
        for (int s = 0; s < 2; s++) begin
            wait_scan();
            settle();
        end
        wait_scan();
        event_clr = 9'h008;
        settle();
        event_clr = '0;
        check("set_beats_clear", touch_event[3], 1);
        check("repress3_touched", touched[3], 1);

        // Pad 7 never discharges.
        k_cfg[7] = NEVER;
        read_sel = 7;
        measure_scan(len);
        check("timeout_measure_cycles", len, 4096);
        settle();
        check("timeout_count7", read_count, 4095);
        for (int s = 1; s < 3; s++) begin
            wait_scan();
            settle();
            check("timeout7_touched", touched[7], (s == 2));
        end
        check("timeout7_event", touch_event, 9'h088);

        // Recalibrate mid-measure with pad 3 held at 60 and pad 7 back to normal.
        k_cfg[7] = 10;
        wait_measure();
        repeat (5) @(posedge clock);
        #1 calibrate = 1'b1;
        settle();
        calibrate = 1'b0;
        wait_scan();
        settle();
        check("recal_keeps_touched", touched, 9'h088);
        read_sel = 3;
        #1 check("recal_count3", read_count, 60);
        for (int s = 0; s < 3; s++) begin
            wait_scan();
            settle();
            check("recal_touched", touched, (s == 2) ? 9'h000 : 9'h088);
        end

        // Reset in the middle of CHARGE.
        wait_charge();
        repeat (10) @(posedge clock);
        #1;
        check("pre_reset_events", touch_event, 9'h088);
        reset = 1'b0;
        #1;
        check("midrst_sensors_out", sensors_out, 0);
        check("midrst_touched", touched, 0);
        check("midrst_touch_event", touch_event, 0);
        check("midrst_calibrated", calibrated, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        wait_scan();
        settle();
        check("post_rst_calibrated", calibrated, 1);
        check("post_rst_count3", read_count, 60);
        for (int s = 0; s < 3; s++) begin
            wait_scan();
            settle();
            check("post_rst_touched", touched, 0);
        end

        read_sel = 12;
        #1 check("read_sel_out_of_range", read_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
